seg_counter_display: RTL and testbench

- Parametrised multi-digit seven-segment pixel renderer for the VGA overlay path.
- Holds a DIGITS-wide BCD value that can be loaded or incremented. Latches that value into a display snapshot at frame start so the picture never tears mid-frame.
- Outputs a registered per-pixel "lit" flag with fixed 2-cycle latency, plus leading-zero blanking and frame-based blinking.

---
 rtl/seg_counter_display.sv | 241 ++++++++++++++++++++++++
 tb/tb_seg_counter_display.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_counter_display.sv
// -----------------------------------------------------------------------------
// seg_counter_display
//
// Multi-digit seven-segment pixel renderer for the VGA overlay path. A BCD
// value register (load / increment) is copied into a display snapshot at each
// frame start, so a frame never shows a half-updated number. For every pixel
// the block answers "is this pixel lit?" with a fixed 2-cycle latency and one
// pixel per clock.
//
// Ports
//   clk, rst_n           pixel clock, synchronous active-low reset
//   s_x, s_y             top-left corner of digit 0
//   len, border, gap     segment length, segment thickness, inter-digit space
//   load_valid/value     load a BCD value (digit 0 in the top nibble)
//   inc                  BCD increment (ignored while load_valid is high)
//   overflow             1-cycle pulse when an increment wraps all digits
//   blank_lz             blank leading zeros (rightmost digit always shown)
//   blink_en             blink the whole display every BLINK_FRAMES frames
//   frame_start          first pixel of a frame; latches the snapshot
//   x, y                 current pixel
//   v                    pixel lit, 2 cycles after x/y
// -----------------------------------------------------------------------------
module seg_counter_display #(
  parameter int DIGITS       = 4,
  parameter int COORD_W      = 32,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COORD_W-1:0]    s_x,
  input  logic [COORD_W-1:0]    s_y,
  input  logic [COORD_W-1:0]    len,
  input  logic [COORD_W-1:0]    border,
  input  logic [COORD_W-1:0]    gap,
  input  logic                  load_valid,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  inc,
  output logic                  overflow,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  input  logic                  frame_start,
  input  logic [COORD_W-1:0]    x,
  input  logic [COORD_W-1:0]    y,
  output logic                  v
);

  // Geometry is evaluated 8 bits wider than the coordinates so that sums and
  // products of large inputs cannot wrap back onto the visible area.
  localparam int WW    = COORD_W + 8;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef logic [WW-1:0] wide_t;

  // Half-open range test [s, s+e).
  function automatic logic in_rng(input wide_t p, input wide_t s, input wide_t e);
    return (p >= s) && (p < s + e);
  endfunction

  // Segment hits {g,f,e,d,c,b,a} for one digit whose left edge is dx.
  function automatic logic [6:0] seg_hit(input wide_t px, input wide_t py,
                                         input wide_t dx, input wide_t sy,
                                         input wide_t b,  input wide_t l);
    logic [6:0] h;
    h[0] = in_rng(px, dx + b,     l) && in_rng(py, sy,                  b);
    h[1] = in_rng(px, dx + b + l, b) && in_rng(py, sy + b,              l);
    h[2] = in_rng(px, dx + b + l, b) && in_rng(py, sy + (b << 1) + l,   l);
    h[3] = in_rng(px, dx + b,     l) && in_rng(py, sy + ((b + l) << 1), b);
    h[4] = in_rng(px, dx,         b) && in_rng(py, sy + (b << 1) + l,   l);
    h[5] = in_rng(px, dx,         b) && in_rng(py, sy + b,              l);
    h[6] = in_rng(px, dx + b,     l) && in_rng(py, sy + b + l,          b);
    return h;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000;  // non-BCD nibble shows a dash
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [4*DIGITS-1:0] snap_q,  snap_d;
  logic                overflow_q, overflow_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [6:0]          hit_q, hit_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                v_q, v_d;

  // ---------------------------------------------------------------------------
  // Value register: load beats increment; increment is a ripple BCD +1 from
  // the least significant digit (lowest nibble). A nibble >= 9 goes to 0 and
  // carries, which also covers the non-BCD nibbles 10-15.
  // ---------------------------------------------------------------------------
  logic [4*DIGITS-1:0] inc_value;
  logic                carry;

  always_comb begin
    // NOTE: every variable driven here gets a value before any branch, so no
    // path through the block leaves it unassigned and no latch is inferred.
    inc_value = value_q;
    carry     = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (value_q[4*k +: 4] >= 4'd9) begin
          inc_value[4*k +: 4] = 4'd0;
        end else begin
          inc_value[4*k +: 4] = value_q[4*k +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_comb begin
    value_d    = value_q;
    overflow_d = 1'b0;
    if (load_valid) begin
      value_d = load_value;
    end else if (inc) begin
      value_d    = inc_value;
      overflow_d = carry;
    end
  end

  // Snapshot takes the value as it stood before this edge's load/inc.
  assign snap_d = frame_start ? value_q : snap_q;

  // ---------------------------------------------------------------------------
  // Blink: count frame starts, flip the phase every BLINK_FRAMES of them.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!blink_en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (frame_start) begin
      if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: geometry. Digit boxes never overlap (pitch >= digit width), so at
  // most one digit reports hits; the lowest index wins for determinism.
  // ---------------------------------------------------------------------------
  wide_t xw, yw, sxw, syw, bw, lw, pitch;
  logic [6:0] cand;

  assign xw    = wide_t'(x);
  assign yw    = wide_t'(y);
  assign sxw   = wide_t'(s_x);
  assign syw   = wide_t'(s_y);
  assign bw    = wide_t'(border);
  assign lw    = wide_t'(len);
  assign pitch = (bw << 1) + lw + wide_t'(gap);

  always_comb begin
    hit_d = '0;
    idx_d = '0;
    cand  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      cand = seg_hit(xw, yw, sxw + wide_t'(i) * pitch, syw, bw, lw);
      if (|cand) begin
        hit_d = cand;
        idx_d = IDX_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: decode the snapshot digit, apply leading-zero blanking and blink.
  // lz[i] is set when digits 0..i are all zero; the last digit is exempt.
  // ---------------------------------------------------------------------------
  logic [DIGITS-1:0] lz;
  logic              zero_run;
  logic [3:0]        cur_digit;

  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      zero_run = zero_run && (snap_q[4*(DIGITS-1-i) +: 4] == 4'd0);
      lz[i]    = zero_run;
    end
    lz[DIGITS-1] = 1'b0;
    cur_digit    = snap_q[4*(DIGITS-1-int'(idx_q)) +: 4];
    v_d          = (|(hit_q & decode(cur_digit)))
                   && !(blank_lz && lz[idx_q])
                   && !(blink_en && phase_q);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge value of every other register, independent of order.
    if (!rst_n) begin
      value_q    <= '0;
      snap_q     <= '0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      hit_q      <= '0;
      idx_q      <= '0;
      v_q        <= 1'b0;
    end else begin
      value_q    <= value_d;
      snap_q     <= snap_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      hit_q      <= hit_d;
      idx_q      <= idx_d;
      v_q        <= v_d;
    end
  end

  assign v        = v_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_seg_counter_display.sv
// -----------------------------------------------------------------------------
// tb_seg_counter_display
//
// Scoreboard bench for seg_counter_display (DIGITS=4, COORD_W=32,
// BLINK_FRAMES=2). Geometry: border=2, len=10, gap=4, origin (0,0), so the
// digit pitch is 18 and digit i occupies x in [18i, 18i+14), y in [0,26).
// The stimulus pushes the hand-derived expected v / overflow into queues; a
// monitor on the falling edge pops and compares when the tracked 2-cycle
// (pixel) or 1-cycle (overflow) response is due.
// -----------------------------------------------------------------------------
module tb_seg_counter_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_x, s_y, len, border, gap;
  logic        load_valid;
  logic [15:0] load_value;
  logic        inc;
  logic        overflow;
  logic        blank_lz, blink_en, frame_start;
  logic [31:0] x, y;
  logic        v;

  seg_counter_display #(
    .DIGITS(4), .COORD_W(32), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_x(s_x), .s_y(s_y), .len(len), .border(border), .gap(gap),
    .load_valid(load_valid), .load_value(load_value), .inc(inc),
    .overflow(overflow),
    .blank_lz(blank_lz), .blink_en(blink_en), .frame_start(frame_start),
    .x(x), .y(y), .v(v)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit    exp;
    string name;
  } exp_t;

  exp_t pix_q[$];
  exp_t ovf_q[$];
  exp_t pop_item;

  int checks   = 0;
  int failures = 0;

  bit pix_valid = 1'b0, pv1 = 1'b0, pv2 = 1'b0;
  bit ovf_chk   = 1'b0, ov1 = 1'b0;

  // Representative pixel for each segment a..g of digit 0.
  int seg_px[7] = '{5, 12, 12, 5, 0, 0, 5};
  int seg_py[7] = '{0, 5, 18, 24, 18, 5, 12};

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  // Response trackers mirror only the latency, not the function.
  always @(posedge clk) begin
    pv1 <= pix_valid;
    pv2 <= pv1;
    ov1 <= ovf_chk;
  end

  always @(negedge clk) begin
    if (pv2 && pix_q.size() != 0) begin
      pop_item = pix_q.pop_front();
      check(pop_item.name, v, pop_item.exp);
    end
    if (ov1 && ovf_q.size() != 0) begin
      pop_item = ovf_q.pop_front();
      check(pop_item.name, overflow, pop_item.exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int px, input int py, input bit e, input string nm);
    exp_t t;
    t.exp  = e;
    t.name = nm;
    x = px;
    y = py;
    pix_valid = 1'b1;
    pix_q.push_back(t);
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic flush();
    pix_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic expect_ovf(input bit e, input string nm);
    exp_t t;
    t.exp  = e;
    t.name = nm;
    ovf_chk = 1'b1;
    ovf_q.push_back(t);
  endtask

  task automatic do_load(input logic [15:0] val);
    load_valid = 1'b1;
    load_value = val;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_inc(input bit e, input string nm);
    inc = 1'b1;
    expect_ovf(e, nm);
    tick();
    inc     = 1'b0;
    ovf_chk = 1'b0;
  endtask

  task automatic idle_ovf(input bit e, input string nm);
    expect_ovf(e, nm);
    tick();
    ovf_chk = 1'b0;
  endtask

  task automatic do_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Probe all seven segments of digit i against the required pattern
  // {g,f,e,d,c,b,a}.
  task automatic check_digit(input int i, input logic [6:0] pat, input string tag);
    for (int s = 0; s < 7; s++)
      present(seg_px[s] + 18 * i, seg_py[s], pat[s],
              $sformatf("%s_d%0d_seg%0d", tag, i, s));
    flush();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_lit;
    bit blink_exp[6] = '{1, 0, 0, 1, 1, 0};

    rst_n = 1'b0;
    s_x = 0; s_y = 0; len = 10; border = 2; gap = 4;
    load_valid = 0; load_value = 0; inc = 0;
    blank_lz = 0; blink_en = 0; frame_start = 0;
    x = 0; y = 0;
    tick();

    // Reset: v and overflow forced low even though (12,3) would be lit.
    for (int k = 0; k < 3; k++) present(12, 3, 1'b0, "reset_v");
    idle_ovf(1'b0, "reset_ovf");
    idle_ovf(1'b0, "reset_ovf");
    rst_n = 1'b1;
    flush();

    // Snapshot cleared to 0: digit 0 shows '0', segment b lit.
    present(12, 3, 1'b1, "post_reset_zero_b");
    idle_ovf(1'b0, "post_reset_ovf");
    flush();

    // 0x1234: digit 0 = '1' -> only b (x 12..13, y 2..11) and c (y 14..23).
    do_load(16'h1234);
    do_frame();
    for (int yy = 0; yy < 26; yy++)
      for (int xx = 0; xx < 18; xx++) begin
        exp_lit = (xx == 12 || xx == 13) &&
                  ((yy >= 2 && yy <= 11) || (yy >= 14 && yy <= 23));
        present(xx, yy, exp_lit, $sformatf("sweep_%0d_%0d", xx, yy));
      end
    flush();
    present(3, 0, 1'b0, "unlit_3_0");
    present(12, 3, 1'b1, "lit_12_3");
    flush();
    check_digit(1, 7'b1011011, "v1234");
    check_digit(3, 7'b1100110, "v1234");

    // 9999 + 1 wraps with a single-cycle overflow, then 0000 + 1 = 0001.
    do_load(16'h9999);
    do_inc(1'b1, "wrap_ovf");
    idle_ovf(1'b0, "wrap_ovf_drop");
    idle_ovf(1'b0, "wrap_ovf_idle");
    do_frame();
    check_digit(0, 7'b0111111, "v0000");
    check_digit(3, 7'b0111111, "v0000");
    do_inc(1'b0, "inc_no_ovf");
    do_frame();
    check_digit(3, 7'b0000110, "v0001");
    check_digit(2, 7'b0111111, "v0001");

    // Carry chain through two digits: 0199 + 1 = 0200.
    do_load(16'h0199);
    do_inc(1'b0, "carry_no_ovf");
    do_frame();
    check_digit(1, 7'b1011011, "v0200");
    check_digit(2, 7'b0111111, "v0200");

    // Load and inc together: load wins, no overflow, value 0042.
    load_valid = 1'b1; load_value = 16'h0042; inc = 1'b1;
    expect_ovf(1'b0, "load_inc_ovf");
    tick();
    load_valid = 1'b0; inc = 1'b0; ovf_chk = 1'b0;
    do_frame();
    check_digit(2, 7'b1100110, "v0042");
    check_digit(3, 7'b1011011, "v0042");

    // Leading-zero blanking.
    blank_lz = 1'b1;
    do_load(16'h0007);
    do_frame();
    for (int i = 0; i < 3; i++) check_digit(i, 7'b0000000, "lz0007");
    check_digit(3, 7'b0000111, "lz0007");
    do_load(16'h0000);
    do_frame();
    for (int i = 0; i < 3; i++) check_digit(i, 7'b0000000, "lz0000");
    check_digit(3, 7'b0111111, "lz0000");
    blank_lz = 1'b0;

    // Mid-frame load is invisible until the next frame start.
    check_digit(2, 7'b0111111, "pre_a5");
    do_load(16'h00A5);
    check_digit(2, 7'b0111111, "mid_a5");
    check_digit(3, 7'b0111111, "mid_a5");
    do_frame();
    check_digit(2, 7'b1000000, "v00a5");
    check_digit(3, 7'b1101101, "v00a5");
    check_digit(0, 7'b0111111, "v00a5");

    // Load in the frame_start cycle lands one frame later.
    load_valid = 1'b1; load_value = 16'h1234; frame_start = 1'b1;
    tick();
    load_valid = 1'b0; frame_start = 1'b0;
    check_digit(3, 7'b1101101, "same_edge");
    do_frame();
    check_digit(3, 7'b1100110, "next_frame");

    // Blink with BLINK_FRAMES=2; probe digit 3 ('4') segment b at (66,5).
    blink_en = 1'b1;
    present(66, 5, 1'b1, "blink_frame1");
    flush();
    for (int k = 0; k < 6; k++) begin
      do_frame();
      present(66, 5, blink_exp[k], $sformatf("blink_frame%0d", k + 2));
      flush();
    end
    present(66, 5, 1'b0, "blink_still_off");
    present(66, 5, 1'b1, "blink_release");
    blink_en = 1'b0;
    present(66, 5, 1'b1, "blink_release_next");
    flush();

    check("queues_drained", logic'(pix_q.size() == 0 && ovf_q.size() == 0), 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
